// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: Wishbone-programmed sequencer for the user-area up-counter.
// Software sets LOAD/CMP/PRESC/mode; the block issues load and prescaled
// increment strobes, watches the counter's value and flags a compare match.
module counter_seq_ctrl #(
  parameter int BITS    = 8,
  parameter int PRESC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            wb_we,
  input  logic [3:0]      wb_sel,
  input  logic [3:0]      wb_adr,
  input  logic [31:0]     wb_wdata,
  output logic            wb_ack,
  output logic [31:0]     wb_rdata,
  input  logic [BITS-1:0] count,
  output logic            cnt_load,
  output logic [BITS-1:0] cnt_load_val,
  output logic            cnt_inc,
  output logic            busy,
  output logic            irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_MATCH = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_CMP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  state_t              state_q, state_d;
  logic                en_q, en_d;
  logic                periodic_q, periodic_d;
  logic                irq_en_q, irq_en_d;
  logic                done_q, done_d;
  logic                ack_q, ack_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PRESC_W-1:0]  pcnt_q, pcnt_d;
  logic [BITS-1:0]     load_q, load_d;
  logic [BITS-1:0]     cmp_q, cmp_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                accept;
  logic                bus_wr;
  logic                bus_rd;
  logic                start_req;
  logic                w1c_done;
  logic                inc_fire;
  logic [31:0]         byte_mask;
  logic [31:0]         ctrl_cur;
  logic [31:0]         ctrl_new;
  logic [31:0]         load_new;
  logic [31:0]         cmp_new;
  logic                unused_bits;

  // A request is taken only while no ack is showing, so acks never repeat back-to-back
  assign accept    = wb_valid && !ack_q;
  assign bus_wr    = accept && wb_we;
  assign bus_rd    = accept && !wb_we;
  assign byte_mask = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};

  // Merge byte-enabled write data into the current value of each register
  always_comb begin
    ctrl_cur                = '0;
    ctrl_cur[0]             = en_q;
    ctrl_cur[1]             = periodic_q;
    ctrl_cur[2]             = irq_en_q;
    ctrl_cur[8 +: PRESC_W]  = presc_q;
    ctrl_new = (ctrl_cur & ~byte_mask) | (wb_wdata & byte_mask);
    load_new = (32'(load_q) & ~byte_mask) | (wb_wdata & byte_mask);
    cmp_new  = (32'(cmp_q) & ~byte_mask) | (wb_wdata & byte_mask);
  end

  // START only counts when the same write leaves EN set
  assign start_req = bus_wr && (wb_adr[3:2] == REG_CTRL) && ctrl_new[3] && ctrl_new[0];
  assign w1c_done  = bus_wr && (wb_adr[3:2] == REG_STATUS) && wb_sel[0] && wb_wdata[1];

  assign unused_bits = ^{wb_adr[1:0], ctrl_new[31:8+PRESC_W], ctrl_new[7:4],
                         load_new[31:BITS], cmp_new[31:BITS]};

  // Register writes and the registered read-data mux for accepted bus cycles
  always_comb begin
    en_d       = en_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    presc_d    = presc_q;
    load_d     = load_q;
    cmp_d      = cmp_q;
    ack_d      = accept;
    rdata_d    = '0;
    if (bus_wr) begin
      case (wb_adr[3:2])
        REG_CTRL: begin
          en_d       = ctrl_new[0];
          periodic_d = ctrl_new[1];
          irq_en_d   = ctrl_new[2];
          presc_d    = ctrl_new[8 +: PRESC_W];
        end
        REG_LOAD: load_d = load_new[BITS-1:0];
        REG_CMP:  cmp_d  = cmp_new[BITS-1:0];
        default:  ;
      endcase
    end
    if (bus_rd) begin
      case (wb_adr[3:2])
        REG_CTRL:   rdata_d = ctrl_cur;
        REG_LOAD:   rdata_d = 32'(load_q);
        REG_CMP:    rdata_d = 32'(cmp_q);
        REG_STATUS: rdata_d = {30'd0, done_q, (state_q != ST_IDLE)};
        default:    rdata_d = '0;
      endcase
    end
  end

  // Sequencer: load, prescaled increments, compare, then reload or stop; DONE set beats W1C
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    inc_fire = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_LOAD: begin
        state_d = ST_RUN;
        pcnt_d  = '0;
      end
      ST_RUN: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count == cmp_q) begin
          state_d = ST_MATCH;
        end else if (pcnt_q == presc_q) begin
          inc_fire = 1'b1;
          pcnt_d   = '0;
        end else begin
          pcnt_d = pcnt_q + PRESC_W'(1);
        end
      end
      ST_MATCH: begin
        if (periodic_q && en_q) state_d = ST_LOAD;
        else                    state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_req) begin
      state_d = ST_LOAD;
      pcnt_d  = '0;
    end
    done_d = done_q;
    if (w1c_done) done_d = 1'b0;
    if (state_d == ST_MATCH) done_d = 1'b1;
  end

  // All state and register flops; synchronous reset returns everything to zero/IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      load_q     <= '0;
      cmp_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      load_q     <= load_d;
      cmp_q      <= cmp_d;
      rdata_q    <= rdata_d;
    end
  end

  // Strobes are gated by reset so an aborted run issues nothing in the reset cycle
  assign cnt_load     = (state_q == ST_LOAD) && !reset;
  assign cnt_inc      = inc_fire && !reset;
  assign cnt_load_val = load_q;
  assign busy         = (state_q != ST_IDLE);
  assign irq          = done_q && irq_en_q;
  assign wb_ack       = ack_q;
  assign wb_rdata     = rdata_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: scoreboard bench for counter_seq_ctrl with a stand-in
// counter datapath and a register/sequence reference model.
module tb_counter_seq_ctrl;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_LOAD   = 4'h4;
  localparam logic [3:0] A_CMP    = 4'h8;
  localparam logic [3:0] A_STATUS = 4'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_sel = 4'h0;
  logic [3:0]  wb_adr = 4'h0;
  logic [31:0] wb_wdata = 32'h0;
  logic        wb_ack;
  logic [31:0] wb_rdata;
  logic [7:0]  count;
  logic        cnt_load;
  logic [7:0]  cnt_load_val;
  logic        cnt_inc;
  logic        busy;
  logic        irq;

  counter_seq_ctrl #(.BITS(8), .PRESC_W(8)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_sel(wb_sel), .wb_adr(wb_adr),
    .wb_wdata(wb_wdata), .wb_ack(wb_ack), .wb_rdata(wb_rdata),
    .count(count), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .cnt_inc(cnt_inc), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  // Stand-in for the counter datapath: load or increment on the edge after a strobe
  always @(posedge clk) begin
    if (reset)         count <= 8'd0;
    else if (cnt_load) count <= cnt_load_val;
    else if (cnt_inc)  count <= count + 8'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         isLoad;
    logic [7:0] value;
    int         gap;
  } strobe_t;

  typedef struct {
    bit          isRead;
    logic [31:0] data;
  } bus_t;

  strobe_t sbQ[$];
  bus_t    busQ[$];
  int      checkCount = 0;
  int      passCount = 0;
  int      lastStrobeCyc = 0;
  bit      prevAck = 1'b0;
  int      dummyCyc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic noteFail(input string name, input string why);
    checkCount++;
    $display("[TB] FAIL %s: %s", name, why);
  endtask

  task automatic pushStrobe(input bit isLoad, input logic [7:0] value, input int gap);
    strobe_t s;
    s.isLoad = isLoad;
    s.value  = value;
    s.gap    = gap;
    sbQ.push_back(s);
  endtask

  // Monitor: pops expected bus responses on ack and expected strobes on cnt_load/cnt_inc
  initial begin
    bus_t    b;
    strobe_t s;
    forever begin
      @(negedge clk);
      if (wb_ack) begin
        checkOutput("ack_single_cycle", 32'(prevAck), 32'd0);
        if (busQ.size() == 0) noteFail("bus_unexpected_ack", "ack with no request outstanding");
        else begin
          b = busQ.pop_front();
          if (b.isRead) checkOutput("rdata", wb_rdata, b.data);
        end
      end
      prevAck = wb_ack;
      if (cnt_load || cnt_inc) begin
        if (cnt_load && cnt_inc) noteFail("strobe_overlap", "cnt_load and cnt_inc together");
        if (sbQ.size() == 0) begin
          noteFail("strobe_unexpected",
                   $sformatf("got load=%0b inc=%0b count=0x%0h, want no strobe", cnt_load, cnt_inc, count));
        end else begin
          s = sbQ.pop_front();
          checkOutput("strobe_kind_is_load", 32'(cnt_load), 32'(s.isLoad));
          if (s.isLoad) checkOutput("load_value", 32'(cnt_load_val), 32'(s.value));
          else          checkOutput("inc_count", 32'(count), 32'(s.value));
          if (s.gap >= 0) checkOutput("strobe_gap", 32'(cyc - lastStrobeCyc), 32'(s.gap));
        end
        lastStrobeCyc = cyc;
      end
    end
  end

  // One bus transfer; returns at the negedge where ack is seen, optionally keeping valid high
  task automatic applyStimulus(input bit we, input logic [3:0] adr, input logic [31:0] data,
                               input logic [3:0] sel, input logic [31:0] expRead,
                               input bit keep, output int ackCyc);
    bus_t b;
    int   n;
    b.isRead = !we;
    b.data   = expRead;
    busQ.push_back(b);
    wb_valid = 1'b1;
    wb_we    = we;
    wb_adr   = adr;
    wb_wdata = data;
    wb_sel   = sel;
    n = 0;
    ackCyc = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack && n < 10);
    if (wb_ack) ackCyc = cyc;
    else begin
      noteFail("bus_timeout", $sformatf("no ack for adr 0x%0h within 10 cycles", adr));
      busQ.delete();
    end
    if (!keep) wb_valid = 1'b0;
  endtask

  task automatic wbWrite(input logic [3:0] adr, input logic [31:0] data);
    int c;
    applyStimulus(1'b1, adr, data, 4'hF, 32'h0, 1'b0, c);
  endtask

  task automatic wbRead(input logic [3:0] adr, input logic [31:0] exp);
    int c;
    applyStimulus(1'b0, adr, 32'h0, 4'hF, exp, 1'b0, c);
  endtask

  // Wait for all expected strobes to appear and the sequencer to go idle
  task automatic waitIdle();
    int n;
    n = 0;
    while ((sbQ.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) noteFail("run_timeout", $sformatf("%0d strobes still pending, busy=%0b", sbQ.size(), busy));
  endtask

  // Reference for a one-shot run: one load, then (CMP-LOAD) mod 256 increments, each PRESC+1 apart
  task automatic runOneShot(input logic [7:0] ld, input logic [7:0] cm, input int ps, input bit ie);
    logic [7:0] diff;
    wbWrite(A_LOAD, 32'(ld));
    wbWrite(A_CMP, 32'(cm));
    diff = cm - ld;
    pushStrobe(1'b1, ld, -1);
    for (int i = 0; i < int'(diff); i++) pushStrobe(1'b0, ld + 8'(i), ps + 1);
    wbWrite(A_CTRL, 32'h9 | (32'(ie) << 2) | (32'(ps) << 8));
    waitIdle();
    wbRead(A_STATUS, 32'h2);
    checkOutput("irq_after_done", 32'(irq), 32'(ie));
    wbWrite(A_STATUS, 32'h2);
    checkOutput("irq_after_w1c", 32'(irq), 32'd0);
    wbRead(A_STATUS, 32'h0);
  endtask

  // Watchdog so a stuck DUT still ends the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a1, a2, hits, n, ld, d, ps, ie;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_wb_ack", 32'(wb_ack), 32'd0);
    checkOutput("reset_cnt_load", 32'(cnt_load), 32'd0);
    checkOutput("reset_cnt_inc", 32'(cnt_inc), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    @(negedge clk);
    wbRead(A_CTRL, 32'h0);
    wbRead(A_LOAD, 32'h0);
    wbRead(A_CMP, 32'h0);
    wbRead(A_STATUS, 32'h0);

    $display("[TB] one-shot LOAD=5 CMP=8 PRESC=0 with IRQ");
    wbWrite(A_LOAD, 32'd5);
    wbWrite(A_CMP, 32'd8);
    pushStrobe(1'b1, 8'd5, -1);
    pushStrobe(1'b0, 8'd5, 1);
    pushStrobe(1'b0, 8'd6, 1);
    pushStrobe(1'b0, 8'd7, 1);
    wbWrite(A_CTRL, 32'h0D);
    wbRead(A_CTRL, 32'h05);
    waitIdle();
    checkOutput("busy_after_oneshot", 32'(busy), 32'd0);
    wbRead(A_STATUS, 32'h2);
    checkOutput("irq_done", 32'(irq), 32'd1);
    wbWrite(A_CTRL, 32'h0);
    checkOutput("irq_en_cleared", 32'(irq), 32'd0);
    wbRead(A_STATUS, 32'h2);
    applyStimulus(1'b1, A_LOAD, 32'hAB, 4'h0, 32'h0, 1'b0, dummyCyc);
    wbRead(A_LOAD, 32'd5);
    wbWrite(A_STATUS, 32'h2);
    wbRead(A_STATUS, 32'h0);

    $display("[TB] one-shot with PRESC=3");
    runOneShot(8'd5, 8'd8, 3, 1'b1);

    $display("[TB] periodic wrap FE->01, then EN cleared mid-run");
    wbWrite(A_LOAD, 32'hFE);
    wbWrite(A_CMP, 32'h01);
    for (int p = 0; p < 3; p++) begin
      pushStrobe(1'b1, 8'hFE, (p == 0) ? -1 : 3);
      pushStrobe(1'b0, 8'hFE, 1);
      pushStrobe(1'b0, 8'hFF, 1);
      if (p < 2) pushStrobe(1'b0, 8'h00, 1);
    end
    wbWrite(A_CTRL, 32'h0B);
    hits = 0;
    n = 0;
    while (hits < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (cnt_inc && count == 8'hFF) hits++;
    end
    if (hits < 3) noteFail("periodic_progress", $sformatf("saw %0d of 3 periods", hits));
    wbWrite(A_CTRL, 32'h02);
    waitIdle();
    repeat (6) @(negedge clk);
    wbRead(A_CTRL, 32'h02);
    wbRead(A_STATUS, 32'h2);
    wbWrite(A_STATUS, 32'h2);
    wbRead(A_STATUS, 32'h0);

    $display("[TB] CMP == LOAD with W1C colliding with the match");
    wbWrite(A_LOAD, 32'h20);
    wbWrite(A_CMP, 32'h20);
    pushStrobe(1'b1, 8'h20, -1);
    applyStimulus(1'b1, A_CTRL, 32'h0D, 4'hF, 32'h0, 1'b1, a1);
    checkOutput("irq_before_match", 32'(irq), 32'd0);
    applyStimulus(1'b1, A_STATUS, 32'h2, 4'hF, 32'h0, 1'b0, a2);
    checkOutput("b2b_ack_spacing", 32'(a2 - a1), 32'd2);
    checkOutput("irq_at_match", 32'(irq), 32'd1);
    waitIdle();
    wbRead(A_STATUS, 32'h2);
    wbWrite(A_STATUS, 32'h2);
    wbRead(A_STATUS, 32'h0);

    $display("[TB] randomized one-shot runs");
    for (int k = 0; k < 8; k++) begin
      ld = int'($urandom_range(0, 255));
      d  = int'($urandom_range(0, 6));
      ps = int'($urandom_range(0, 3));
      ie = int'($urandom_range(0, 1));
      if (k == 0) begin
        ld = 252;
        d  = 6;
      end
      runOneShot(8'(ld), 8'(ld + d), ps, ie[0]);
    end

    $display("[TB] reset in the middle of a run");
    wbWrite(A_LOAD, 32'h0);
    wbWrite(A_CMP, 32'd200);
    pushStrobe(1'b1, 8'h00, -1);
    for (int i = 0; i < 200; i++) pushStrobe(1'b0, 8'(i), 2);
    wbWrite(A_CTRL, 32'h10D);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("abort_cnt_inc", 32'(cnt_inc), 32'd0);
    checkOutput("abort_cnt_load", 32'(cnt_load), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_irq", 32'(irq), 32'd0);
    sbQ.delete();
    @(negedge clk);
    wbRead(A_CTRL, 32'h0);
    wbRead(A_LOAD, 32'h0);
    wbRead(A_CMP, 32'h0);
    wbRead(A_STATUS, 32'h0);
    repeat (10) @(negedge clk);

    checkOutput("strobe_queue_drained", 32'(sbQ.size()), 32'd0);
    checkOutput("bus_queue_drained", 32'(busQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
